// File: rtl/pmod_cls_pkg.sv
// Shared constants, FSM state type and column-to-ASCII helper for the PMOD CLS driver.
package pmod_cls_pkg;

    localparam logic [7:0] ASC_ESC  = 8'h1B;
    localparam logic [7:0] ASC_LBRK = 8'h5B;
    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_SEMI = 8'h3B;
    localparam logic [7:0] ASC_J    = 8'h6A;
    localparam logic [7:0] ASC_H    = 8'h48;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_CMD_RUN  = 3'd3,
        ST_CMD_WAIT = 3'd4,
        ST_DAT_RUN  = 3'd5,
        ST_DAT_WAIT = 3'd6
    } state_e;

    // Decimal rendering of a column: cnt is 1 or 2, tens is only meaningful when cnt is 2.
    typedef struct packed {
        logic [1:0] cnt;
        logic [7:0] tens;
        logic [7:0] ones;
    } col_digits_t;

    function automatic col_digits_t col_digits(input logic [7:0] col);
        col_digits_t r;
        logic [7:0]  t;
        t      = col / 8'd10;
        r.cnt  = (t != 8'd0) ? 2'd2 : 2'd1;
        r.tens = ASC_ZERO + t;
        r.ones = ASC_ZERO + (col - (t * 8'd10));
        return r;
    endfunction

endpackage

// File: rtl/pmod_cls_multi_spi_solo.sv
// PMOD CLS display driver: turns clear/write requests into ESC cursor sequences and
// text bursts pushed to a generic SPI master, one SPI transaction per sequence.
module pmod_cls_multi_spi_solo
    import pmod_cls_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int PARM_ROWS            = 2,
    parameter int PARM_COLS            = 16,
    parameter int parm_tx_len_bits     = 11,
    parameter int parm_wait_cyc_bits   = 2,
    parameter int parm_rx_len_bits     = 11
) (
    input  logic                                i_ext_spi_clk_x,
    input  logic                                i_arst_n,
    input  logic                                i_spi_ce_4x,
    output logic                                o_go_stand,
    input  logic                                i_spi_idle,
    output logic [parm_tx_len_bits-1:0]         o_tx_len,
    output logic [parm_wait_cyc_bits-1:0]       o_wait_cyc,
    output logic [parm_rx_len_bits-1:0]         o_rx_len,
    output logic [7:0]                          o_tx_data,
    output logic                                o_tx_enqueue,
    input  logic                                i_tx_ready,
    input  logic [7:0]                          i_rx_data,
    input  logic                                i_rx_valid,
    input  logic                                i_rx_avail,
    output logic                                o_rx_dequeue,
    output logic                                o_command_ready,
    input  logic                                i_cmd_clear,
    input  logic                                i_cmd_write,
    input  logic [$clog2(PARM_ROWS+1)-1:0]      i_row,
    input  logic [$clog2(PARM_COLS+1)-1:0]      i_col,
    input  logic [$clog2(PARM_COLS+1)-1:0]      i_len,
    input  logic [PARM_COLS*8-1:0]              i_text,
    output logic                                o_cmd_error,
    output logic                                o_cmd_done
);

    localparam int COL_W      = $clog2(PARM_COLS + 1);
    localparam int TXT_W      = PARM_COLS * 8;
    localparam int TXL_W      = parm_tx_len_bits;
    localparam int BOOT_TICKS = (FCLK_ce / 1000) * ((parm_fast_simulation != 0) ? 2 : 800) - 1;
    localparam int TMR_W      = $clog2(BOOT_TICKS + 1) + 1;
    localparam logic [TMR_W-1:0] BOOT_LAST = TMR_W'((BOOT_TICKS > 0) ? (BOOT_TICKS - 1) : 0);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [55:0]        cmd_seq_q, cmd_seq_d;
    logic [2:0]         cmd_len_q, cmd_len_d, cmd_rem_q, cmd_rem_d;
    logic [TXT_W-1:0]   dat_seq_q, dat_seq_d;
    logic [COL_W-1:0]   dat_len_q, dat_len_d, dat_rem_q, dat_rem_d;
    logic [TXL_W-1:0]   tx_len_q, tx_len_d;
    logic               ready_q, ready_d, err_q, err_d, done_q, done_d;
    logic               enq_s, last_s, req_bad_s;
    logic [7:0]         row_ext_s, col_ext_s, len_ext_s, row_chr_s;
    col_digits_t        digits_s;
    logic               unused_s;

    assign row_ext_s = 8'(i_row);
    assign col_ext_s = 8'(i_col);
    assign len_ext_s = 8'(i_len);
    assign row_chr_s = ASC_ZERO + row_ext_s;
    assign digits_s  = col_digits(col_ext_s);
    assign req_bad_s = (row_ext_s >= 8'(PARM_ROWS)) || (col_ext_s >= 8'(PARM_COLS)) ||
                       (len_ext_s == 8'd0) || ((col_ext_s + len_ext_s) > 8'(PARM_COLS));

    // The RX side of the SPI master is not needed for a write-only display.
    assign unused_s     = ^{i_rx_data, i_rx_valid, i_rx_avail};
    assign o_rx_dequeue = 1'b0;
    assign o_wait_cyc   = '0;
    assign o_rx_len     = '0;

    // Push strobes are qualified by ce so each byte is offered for exactly one clock.
    assign o_tx_enqueue    = enq_s & i_spi_ce_4x;
    assign o_go_stand      = enq_s & last_s & i_spi_ce_4x;
    assign o_tx_data       = (state_q == ST_CMD_RUN) ? cmd_seq_q[55:48] :
                             (state_q == ST_DAT_RUN) ? dat_seq_q[TXT_W-1 -: 8] : 8'h00;
    assign o_tx_len        = tx_len_q;
    assign o_command_ready = ready_q;
    assign o_cmd_error     = err_q;
    assign o_cmd_done      = done_q;

    // Next-state, sequence building and byte sequencing for the command FSM.
    always_comb begin
        state_d   = state_q;
        cmd_seq_d = cmd_seq_q;
        cmd_len_d = cmd_len_q;
        cmd_rem_d = cmd_rem_q;
        dat_seq_d = dat_seq_q;
        dat_len_d = dat_len_q;
        dat_rem_d = dat_rem_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        enq_s     = 1'b0;
        last_s    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (timer_q >= BOOT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BOOT;
                end
            end
            ST_IDLE: begin
                if (i_cmd_clear) begin
                    cmd_seq_d = {ASC_ESC, ASC_LBRK, ASC_ZERO, ASC_J, 24'h000000};
                    cmd_len_d = 3'd4;
                    cmd_rem_d = 3'd4;
                    dat_seq_d = '0;
                    dat_len_d = '0;
                    dat_rem_d = '0;
                    state_d   = ST_LOAD;
                end else if (i_cmd_write) begin
                    if (req_bad_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        if (digits_s.cnt == 2'd2) begin
                            cmd_seq_d = {ASC_ESC, ASC_LBRK, row_chr_s, ASC_SEMI,
                                         digits_s.tens, digits_s.ones, ASC_H};
                            cmd_len_d = 3'd7;
                            cmd_rem_d = 3'd7;
                        end else begin
                            cmd_seq_d = {ASC_ESC, ASC_LBRK, row_chr_s, ASC_SEMI,
                                         digits_s.ones, ASC_H, 8'h00};
                            cmd_len_d = 3'd6;
                            cmd_rem_d = 3'd6;
                        end
                        dat_seq_d = i_text;
                        dat_len_d = i_len;
                        dat_rem_d = i_len;
                        state_d   = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_CMD_RUN;
            end
            ST_CMD_RUN: begin
                if (i_tx_ready) begin
                    enq_s     = 1'b1;
                    cmd_seq_d = cmd_seq_q << 8;
                    cmd_rem_d = cmd_rem_q - 3'd1;
                    if (cmd_rem_q == 3'd1) begin
                        last_s  = 1'b1;
                        state_d = ST_CMD_WAIT;
                    end else begin
                        state_d = ST_CMD_RUN;
                    end
                end else begin
                    state_d = ST_CMD_RUN;
                end
            end
            ST_CMD_WAIT: begin
                if (!i_spi_idle) begin
                    state_d = ST_CMD_WAIT;
                end else if (dat_len_q != '0) begin
                    state_d = ST_DAT_RUN;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DAT_RUN: begin
                if (i_tx_ready) begin
                    enq_s     = 1'b1;
                    dat_seq_d = dat_seq_q << 8;
                    dat_rem_d = dat_rem_q - COL_W'(1);
                    if (dat_rem_q == COL_W'(1)) begin
                        last_s  = 1'b1;
                        state_d = ST_DAT_WAIT;
                    end else begin
                        state_d = ST_DAT_RUN;
                    end
                end else begin
                    state_d = ST_DAT_RUN;
                end
            end
            ST_DAT_WAIT: begin
                if (i_spi_idle) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DAT_WAIT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != {TMR_W{1'b1}}) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end

        if (state_d == ST_CMD_RUN) begin
            tx_len_d = TXL_W'(cmd_len_d);
        end else if (state_d == ST_DAT_RUN) begin
            tx_len_d = TXL_W'(dat_len_d);
        end else begin
            tx_len_d = '0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State, sequencer and status registers; everything advances only on a ce tick.
    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_BOOT;
            timer_q   <= '0;
            cmd_seq_q <= '0;
            cmd_len_q <= '0;
            cmd_rem_q <= '0;
            dat_seq_q <= '0;
            dat_len_q <= '0;
            dat_rem_q <= '0;
            tx_len_q  <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (i_spi_ce_4x) begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cmd_seq_q <= cmd_seq_d;
            cmd_len_q <= cmd_len_d;
            cmd_rem_q <= cmd_rem_d;
            dat_seq_q <= dat_seq_d;
            dat_len_q <= dat_len_d;
            dat_rem_q <= dat_rem_d;
            tx_len_q  <= tx_len_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_pmod_cls_multi_spi_solo.sv
// Directed bench for the PMOD CLS driver: boot timing, clear, writes, rejects,
// back-pressure and reset during a data burst. ce is high every second clock.
module tb_pmod_cls_multi_spi_solo;

    localparam int ROWS = 2;
    localparam int COLS = 16;
    localparam int RW   = $clog2(ROWS + 1);
    localparam int CW   = $clog2(COLS + 1);

    logic                clk = 1'b0;
    logic                i_arst_n, i_spi_ce_4x, i_spi_idle, i_tx_ready;
    logic [7:0]          i_rx_data;
    logic                i_rx_valid, i_rx_avail;
    logic                i_cmd_clear, i_cmd_write;
    logic [RW-1:0]       i_row;
    logic [CW-1:0]       i_col, i_len;
    logic [COLS*8-1:0]   i_text;
    logic                o_go_stand, o_tx_enqueue, o_rx_dequeue, o_command_ready;
    logic                o_cmd_error, o_cmd_done;
    logic [10:0]         o_tx_len, o_rx_len;
    logic [1:0]          o_wait_cyc;
    logic [7:0]          o_tx_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  byte_q [$];
    logic [10:0] golen_q [$];
    int          go_cnt = 0;
    int          stray  = 0;

    pmod_cls_multi_spi_solo #(
        .parm_fast_simulation(1), .FCLK_ce(2500000), .PARM_ROWS(ROWS), .PARM_COLS(COLS),
        .parm_tx_len_bits(11), .parm_wait_cyc_bits(2), .parm_rx_len_bits(11)
    ) dut (
        .i_ext_spi_clk_x(clk), .i_arst_n(i_arst_n), .i_spi_ce_4x(i_spi_ce_4x),
        .o_go_stand(o_go_stand), .i_spi_idle(i_spi_idle), .o_tx_len(o_tx_len),
        .o_wait_cyc(o_wait_cyc), .o_rx_len(o_rx_len), .o_tx_data(o_tx_data),
        .o_tx_enqueue(o_tx_enqueue), .i_tx_ready(i_tx_ready), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .i_rx_avail(i_rx_avail), .o_rx_dequeue(o_rx_dequeue),
        .o_command_ready(o_command_ready), .i_cmd_clear(i_cmd_clear),
        .i_cmd_write(i_cmd_write), .i_row(i_row), .i_col(i_col), .i_len(i_len),
        .i_text(i_text), .o_cmd_error(o_cmd_error), .o_cmd_done(o_cmd_done)
    );

    always #5 clk = ~clk;

    // Record every pushed byte and every go strobe with the length presented alongside it.
    always @(posedge clk) begin
        if (o_tx_enqueue) begin
            byte_q.push_back(o_tx_data);
            if (!i_spi_ce_4x || !i_tx_ready) stray <= stray + 1;
        end
        if (o_go_stand) begin
            go_cnt <= go_cnt + 1;
            golen_q.push_back(o_tx_len);
        end
    end

    // One ce tick: ce high for one clock, then low for one clock.
    task automatic ce_step();
        @(negedge clk);
        i_spi_ce_4x = 1'b1;
        @(negedge clk);
        i_spi_ce_4x = 1'b0;
    endtask

    task automatic step_until_bytes(input int target, input int budget, output bit timed_out);
        int n;
        n = 0;
        while (byte_q.size() < target && n < budget) begin
            ce_step();
            n++;
        end
        timed_out = (byte_q.size() < target);
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0;
        i_spi_ce_4x = 1'b1;
        repeat (4) @(negedge clk);
        i_spi_ce_4x = 1'b0;
        checks++;
        if (o_command_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", o_command_ready);
        end
        checks++;
        if ({o_tx_enqueue, o_go_stand, o_cmd_done, o_cmd_error, o_rx_dequeue} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000",
                {o_tx_enqueue, o_go_stand, o_cmd_done, o_cmd_error, o_rx_dequeue});
        end
        checks++;
        if ({o_tx_len, o_tx_data, o_wait_cyc, o_rx_len} !== 32'd0) begin
            errors++; $display("FAIL reset_buses: got %h want 0", {o_tx_len, o_tx_data, o_wait_cyc, o_rx_len});
        end
    endtask

    task automatic test_boot(input string tag);
        @(negedge clk);
        i_arst_n = 1'b1;
        repeat (4998) ce_step();
        checks++;
        if (o_command_ready !== 1'b0) begin
            errors++; $display("FAIL %s_early: ready=%b after 4998 ticks want 0", tag, o_command_ready);
        end
        ce_step();
        checks++;
        if (o_command_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: ready=%b after 4999 ticks want 1", tag, o_command_ready);
        end
    endtask

    task automatic test_clear();
        logic [7:0] exp [4];
        bit to;
        exp = '{8'h1B, 8'h5B, 8'h30, 8'h6A};
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        // Clear wins over a simultaneous (invalid) write.
        i_cmd_clear = 1'b1; i_cmd_write = 1'b1; i_row = 2'd2; i_col = '0; i_len = '0;
        ce_step();
        i_cmd_clear = 1'b0; i_cmd_write = 1'b0;
        checks++;
        if (o_cmd_error !== 1'b0 || o_command_ready !== 1'b0) begin
            errors++; $display("FAIL clear_accept: err=%b ready=%b want 0 0", o_cmd_error, o_command_ready);
        end
        ce_step();
        checks++;
        if (byte_q.size() != 0) begin
            errors++; $display("FAIL clear_latency_early: bytes=%0d want 0", byte_q.size());
        end
        ce_step();
        checks++;
        if (byte_q.size() != 1) begin
            errors++; $display("FAIL clear_latency: bytes=%0d want 1", byte_q.size());
        end
        step_until_bytes(4, 20, to);
        ce_step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= byte_q.size() || byte_q[i] !== exp[i]) begin
                errors++; $display("FAIL clear_byte%0d: got %h want %h", i,
                    (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (byte_q.size() != 4 || go_cnt != 1 || golen_q.size() != 1 || golen_q[0] !== 11'd4) begin
            errors++; $display("FAIL clear_go: bytes=%0d go=%0d len=%0d want 4 1 4", byte_q.size(), go_cnt,
                (golen_q.size() > 0) ? int'(golen_q[0]) : -1);
        end
        checks++;
        if (o_cmd_done !== 1'b0) begin
            errors++; $display("FAIL clear_done_early: done=%b want 0", o_cmd_done);
        end
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        checks++;
        if (o_cmd_done !== 1'b1 || o_command_ready !== 1'b1) begin
            errors++; $display("FAIL clear_done: done=%b ready=%b want 1 1", o_cmd_done, o_command_ready);
        end
        ce_step();
        checks++;
        if (o_cmd_done !== 1'b0) begin
            errors++; $display("FAIL clear_done_width: done=%b want 0", o_cmd_done);
        end
    endtask

    task automatic test_write_two_digit();
        logic [7:0] exp [10];
        bit to;
        exp = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h31, 8'h32, 8'h48, 8'h41, 8'h42, 8'h43};
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        i_row = 2'd1; i_col = 5'd12; i_len = 5'd3; i_text = {24'h414243, 104'h0};
        i_cmd_write = 1'b1;
        ce_step();
        i_cmd_write = 1'b0;
        // Request fields only matter on the accepting tick.
        i_row = '0; i_col = '0; i_len = '0; i_text = '1;
        step_until_bytes(7, 20, to);
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        checks++;
        if (o_cmd_done !== 1'b0) begin
            errors++; $display("FAIL wr2_done_between: done=%b want 0", o_cmd_done);
        end
        step_until_bytes(10, 20, to);
        checks++;
        if (to || byte_q.size() != 10) begin
            errors++; $display("FAIL wr2_count: bytes=%0d want 10", byte_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= byte_q.size() || byte_q[i] !== exp[i]) begin
                errors++; $display("FAIL wr2_byte%0d: got %h want %h", i,
                    (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (golen_q.size() != 2 || golen_q[0] !== 11'd7 || golen_q[1] !== 11'd3) begin
            errors++; $display("FAIL wr2_golen: n=%0d want lengths 7,3", golen_q.size());
        end
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        checks++;
        if (o_cmd_done !== 1'b1) begin
            errors++; $display("FAIL wr2_done: done=%b want 1", o_cmd_done);
        end
    endtask

    task automatic test_write_one_digit();
        logic [7:0] exp [13];
        bit to;
        exp = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h39, 8'h48,
                8'h50, 8'h4D, 8'h4F, 8'h44, 8'h43, 8'h4C, 8'h53};
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        ce_step();
        // col 9 + len 7 lands exactly on the last column.
        i_row = 2'd0; i_col = 5'd9; i_len = 5'd7; i_text = {56'h504D4F44434C53, 72'h0};
        i_cmd_write = 1'b1;
        ce_step();
        i_cmd_write = 1'b0;
        checks++;
        if (o_cmd_error !== 1'b0) begin
            errors++; $display("FAIL wr1_err: err=%b want 0", o_cmd_error);
        end
        step_until_bytes(6, 20, to);
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        step_until_bytes(13, 20, to);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (i >= byte_q.size() || byte_q[i] !== exp[i]) begin
                errors++; $display("FAIL wr1_byte%0d: got %h want %h", i,
                    (i < byte_q.size()) ? byte_q[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (golen_q.size() != 2 || golen_q[0] !== 11'd6 || golen_q[1] !== 11'd7) begin
            errors++; $display("FAIL wr1_golen: n=%0d want lengths 6,7", golen_q.size());
        end
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        ce_step();
    endtask

    task automatic test_reject();
        logic [RW-1:0] rows [3];
        logic [CW-1:0] cols [3];
        logic [CW-1:0] lens [3];
        rows = '{2'd0, 2'd2, 2'd0};
        cols = '{5'd10, 5'd0, 5'd0};
        lens = '{5'd7, 5'd1, 5'd0};
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            i_row = rows[k]; i_col = cols[k]; i_len = lens[k]; i_text = {COLS{8'h5A}};
            i_cmd_write = 1'b1;
            ce_step();
            i_cmd_write = 1'b0;
            checks++;
            if (o_cmd_error !== 1'b1 || o_command_ready !== 1'b1 || o_cmd_done !== 1'b0) begin
                errors++; $display("FAIL reject%0d_pulse: err=%b ready=%b done=%b want 1 1 0",
                    k, o_cmd_error, o_command_ready, o_cmd_done);
            end
            ce_step();
            checks++;
            if (o_cmd_error !== 1'b0) begin
                errors++; $display("FAIL reject%0d_width: err=%b want 0", k, o_cmd_error);
            end
        end
        repeat (4) ce_step();
        checks++;
        if (byte_q.size() != 0 || go_cnt != 0) begin
            errors++; $display("FAIL reject_traffic: bytes=%0d go=%0d want 0 0", byte_q.size(), go_cnt);
        end
    endtask

    task automatic test_back_pressure();
        logic [127:0] exp_txt;
        bit           to;
        int           g0;
        exp_txt = "0123456789ABCDEF";
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        i_row = 2'd1; i_col = 5'd0; i_len = 5'd16; i_text = exp_txt;
        i_cmd_write = 1'b1;
        ce_step();
        i_cmd_write = 1'b0;
        step_until_bytes(6, 20, to);
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        g0 = go_cnt;
        for (int k = 0; k < 80 && byte_q.size() < 22; k++) begin
            i_tx_ready = (k % 2 == 0);
            ce_step();
        end
        i_tx_ready = 1'b1;
        repeat (2) ce_step();
        checks++;
        if (byte_q.size() != 22) begin
            errors++; $display("FAIL bp_count: bytes=%0d want 22", byte_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i + 6 >= byte_q.size() || byte_q[i+6] !== exp_txt[127-8*i -: 8]) begin
                errors++; $display("FAIL bp_byte%0d: got %h want %h", i,
                    (i + 6 < byte_q.size()) ? byte_q[i+6] : 8'hxx, exp_txt[127-8*i -: 8]);
            end
        end
        checks++;
        if (go_cnt - g0 != 1 || golen_q.size() != 2 || golen_q[1] !== 11'd16) begin
            errors++; $display("FAIL bp_go: data_go=%0d n=%0d want 1 go with len 16", go_cnt - g0, golen_q.size());
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL bp_qualify: stray_enqueues=%0d want 0", stray);
        end
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        checks++;
        if (o_cmd_done !== 1'b1) begin
            errors++; $display("FAIL bp_done: done=%b want 1", o_cmd_done);
        end
        ce_step();
    endtask

    task automatic test_reset_mid();
        bit to;
        int n0, g0;
        byte_q.delete(); golen_q.delete(); go_cnt = 0;
        i_row = 2'd0; i_col = 5'd0; i_len = 5'd16; i_text = "ZYXWVUTSRQPONMLK";
        i_cmd_write = 1'b1;
        ce_step();
        i_cmd_write = 1'b0;
        step_until_bytes(6, 20, to);
        i_spi_idle = 1'b1;
        ce_step();
        i_spi_idle = 1'b0;
        step_until_bytes(9, 20, to);
        checks++;
        if (to || o_tx_len !== 11'd16) begin
            errors++; $display("FAIL rstmid_in_burst: bytes=%0d tx_len=%0d want 9 16", byte_q.size(), o_tx_len);
        end
        @(negedge clk);
        i_spi_ce_4x = 1'b1;
        i_arst_n = 1'b0;
        #1;
        checks++;
        if ({o_tx_enqueue, o_go_stand, o_command_ready, o_cmd_done, o_cmd_error} !== 5'b0 ||
            o_tx_len !== 11'd0 || o_tx_data !== 8'd0) begin
            errors++; $display("FAIL rstmid_outputs: enq=%b go=%b rdy=%b len=%0d data=%h want all 0",
                o_tx_enqueue, o_go_stand, o_command_ready, o_tx_len, o_tx_data);
        end
        n0 = byte_q.size();
        g0 = go_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (byte_q.size() != n0 || go_cnt != g0) begin
            errors++; $display("FAIL rstmid_quiet: bytes=%0d go=%0d want %0d %0d", byte_q.size(), go_cnt, n0, g0);
        end
        i_spi_ce_4x = 1'b0;
        test_boot("reboot");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst_n = 1'b0; i_spi_ce_4x = 1'b0; i_spi_idle = 1'b0; i_tx_ready = 1'b1;
        i_rx_data = 8'h00; i_rx_valid = 1'b0; i_rx_avail = 1'b0;
        i_cmd_clear = 1'b0; i_cmd_write = 1'b0;
        i_row = '0; i_col = '0; i_len = '0; i_text = '0;
        test_reset();
        test_boot("boot");
        test_clear();
        test_write_two_digit();
        test_write_one_digit();
        test_reject();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_cls_multi_spi_solo.md
# pmod_cls_multi_spi_solo

Parametrised PMOD CLS display driver in SPI Mode 0. It sits between FPGA application logic and `pmod_generic_spi_solo`. It supports configurable display geometry, clear-display, and variable-length text writes at any row/column. Each command is sent as an ESC cursor/clear sequence, then an optional text burst, as separate SPI transactions. Out-of-range requests are rejected with an error pulse and produce no SPI traffic.

## Interface
- parm_fast_simulation, 0: nonzero shortens the boot wait to 2 ms; zero gives 800 ms.
- FCLK_ce, 2500000: rate in Hz of i_spi_ce_4x.
- PARM_ROWS, 2: display rows, 1..9.
- PARM_COLS, 16: display columns, 1..40.
- parm_tx_len_bits, 11; parm_wait_cyc_bits, 2; parm_rx_len_bits, 11: widths of the generic SPI interface.
- i_ext_spi_clk_x  in  1  sole clock.
- i_arst_n  in  1  reset; asynchronous assert, active-low.
- i_spi_ce_4x  in  1  clock enable; the FSM and timer advance only when this is high.
- o_go_stand, i_spi_idle, o_tx_len, o_wait_cyc, o_rx_len  out/in/out/out/out  1/1/tx_len/wait/rx_len  generic SPI control.
- o_tx_data  out  8  TX FIFO byte.
- o_tx_enqueue  out  1  TX FIFO push.
- i_tx_ready  in  1  TX FIFO can accept a byte.
- i_rx_data, i_rx_valid, i_rx_avail  in  8/1/1  unused.
- o_rx_dequeue  out  1  tied 0.
- o_command_ready  out  1  driver idle; commands are accepted.
- i_cmd_clear  in  1  clear-display request.
- i_cmd_write  in  1  text-write request.
- i_row  in  $clog2(PARM_ROWS+1)  target row, 0-based.
- i_col  in  $clog2(PARM_COLS+1)  start column, 0-based.
- i_len  in  $clog2(PARM_COLS+1)  character count.
- i_text  in  PARM_COLS*8  characters; i_text[PARM_COLS*8-1 -: 8] is the first character.
- o_cmd_error  out  1  one-ce pulse when a request is rejected.
- o_cmd_done  out  1  one-ce pulse when a command's last SPI transaction returns idle.

## Operation
- **States:** BOOT, IDLE, LOAD, CMD_RUN, CMD_WAIT, DAT_RUN, DAT_WAIT.
- **Reset:**
  - Enters BOOT.
  - All outputs are 0, including o_command_ready.
  - Auxiliary registers (sequence, lengths, text copy) are 0.
- **BOOT:** stays until the boot timer reaches FCLK_ce/1000*(fast?2:800)-1 ce ticks, then goes to IDLE.
- **IDLE:**
  - o_command_ready=1.
  - Priority is clear > write.
  - A write is rejected when i_row>=PARM_ROWS, i_col>=PARM_COLS, i_len==0, or i_col+i_len>PARM_COLS. On rejection: pulse o_cmd_error and stay in IDLE.
  - An accepted request goes to LOAD.
- **LOAD:** latches the request into the auxiliary registers.
  - Clear sequence: ESC '[' '0' 'j' (4 bytes); no data.
  - Write sequence: ESC '[' r ';' c 'H', where r = '0'+i_row.
  - c is decimal ASCII with no leading zero: 1 digit for col<10, 2 digits otherwise. The sequence is therefore 6 or 7 bytes.
  - Data is i_len bytes taken from i_text, first character first.
- **CMD_RUN / DAT_RUN:**
  - Each ce with i_tx_ready=1 enqueues the next byte (MSB-first order) and decrements the remaining count.
  - o_tx_len holds the sequence length while in the state.
  - o_go_stand=1 on the ce that enqueues the final byte. The state then moves to the matching WAIT.
- **CMD_WAIT:** when i_spi_idle=1, go to DAT_RUN if the data length is >0; otherwise pulse o_cmd_done and go to IDLE.
- **DAT_WAIT:** when i_spi_idle=1, pulse o_cmd_done and go to IDLE.
- o_wait_cyc=0 and o_rx_len=0 always.
- Unused state encodings recover to BOOT.

## Timing
- **Enqueue qualification:** o_tx_enqueue = run-state & i_tx_ready & i_spi_ce_4x, so it is high for at most one clock per ce.
- **Go pulse:** o_go_stand follows the same qualification, only on the final byte.
- **Request acceptance:** requests are sampled only on a ce while in IDLE; requests at other times are ignored.
  - i_row/i_col/i_len/i_text need only be valid on that sample.
- **Latency:** accepting ce → first enqueue is 2 ce (LOAD, then RUN), given i_tx_ready=1.
- **Throughput:** one byte per ce while i_tx_ready=1; i_tx_ready low stalls with no byte lost or duplicated.
- **Timer:** clears on every state change and saturates at its maximum.
- **Reset mid-transfer:** the FSM returns to BOOT and re-waits the full boot time. No further enqueue or go occurs after assertion.
- **Pulse width:** o_cmd_error and o_cmd_done last one ce period, registered and aligned to the transitioning ce.

## Structure
- **Package pmod_cls_pkg:**
  - ASCII constants ESC, '[', '0', ';', 'j', 'H'.
  - The state enum.
  - A function returning the decimal digit bytes and digit count for a column.
- **Module layout:** a single module with no sub-module. The sequence builder is the package function; the byte sequencers are two counter/shift registers inside the FSM.

## Test plan
- **Boot:** fast sim, FCLK_ce=2.5 MHz → o_command_ready rises after exactly 4999 ce ticks from reset release.
- **Clear:** i_cmd_clear → bytes 1B 5B 30 6A; o_go_stand on the 4th byte with o_tx_len=4; o_cmd_done after i_spi_idle.
- **Two-digit column:** write row=1, col=12, len=3, text "ABC" → cmd 1B 5B 31 3B 31 32 48 (tx_len 7); data 41 42 43 (tx_len 3).
- **Rejections:** write col=10, len=7 with COLS=16 → o_cmd_error pulse, no enqueue. Same for row=2 when ROWS=2, and for len=0.
- **Back-pressure:** toggle i_tx_ready 1/0 every ce during a 16-byte data burst → byte stream is intact and in order; exactly one o_go_stand.
- **Reset mid-transfer:** assert i_arst_n low during DAT_RUN → all outputs 0 immediately; after release, BOOT waits the full time again.
